// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions. Buffer depth is selected by the
// FETCH_PREFETCH_EN macro: defined -> 2-entry prefetch buffer, undefined -> 1 entry.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam int CNT_W = 2;

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer between fetch and decode: DEPTH=1 holding register or
// DEPTH=2 circular buffer with push/pop/flush; head reads as zero when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int W     = INSTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [W-1:0]     o_head
);

  if (DEPTH == 1) begin : g_reg
    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_push) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end
    end

    assign o_empty = !r_valid;
    assign o_count = CNT_W'(r_valid);
    assign o_head  = r_valid ? r_data : '0;
  end else begin : g_ring
    logic [W-1:0]     r_mem [2];
    logic             r_rd;
    logic             r_wr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
        r_rd    <= 1'b0;
        r_wr    <= 1'b0;
        r_count <= '0;
      end else begin
        if (i_push) r_wr <= ~r_wr;
        if (i_pop)  r_rd <= ~r_rd;
        r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
    end

    // NOTE: storage is not reset; the head is masked to zero while the count is zero.
    always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, redirect/discard and HALT.
// Prefetch depth follows FETCH_PREFETCH_EN (see fetch_pkg).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  input  logic               i_hazard_stall,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_halted
);

  fetch_state_e      r_state, w_state_pre, w_state_next;
  logic [ADDR_W-1:0] r_pc, r_addr, w_pc_base;
  logic              r_req, r_outstanding, r_discard, w_discard_next;
  logic              w_rsp, w_push, w_pop, w_issue, w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ_next;

  assign w_rsp  = r_outstanding & i_imem_rvalid;
  assign w_push = w_rsp & ~r_discard & ~i_redirect_valid;
  assign w_pop  = o_instr_valid & ~i_hazard_stall;

  // Occupancy after this edge decides whether a new request fits.
  assign w_occ_next = i_redirect_valid ? '0
                    : {1'b0, w_count} + (CNT_W+1)'(w_push) - (CNT_W+1)'(w_pop);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_pre    = r_state;
    w_discard_next = r_discard;
    w_pc_base      = r_pc;
    if (i_redirect_valid) begin
      w_pc_base = i_redirect_pc;
      if (r_outstanding && !i_imem_rvalid) begin
        w_discard_next = 1'b1;
        w_state_pre    = WAIT;
      end else begin
        w_discard_next = 1'b0;
        w_state_pre    = FETCH;
      end
    end else if (r_state == WAIT && w_rsp) begin
      w_discard_next = 1'b0;
      w_state_pre    = (!r_discard && is_halt(i_imem_rdata)) ? HALT : FETCH;
    end
    w_issue      = (w_state_pre == FETCH) && (w_occ_next < (CNT_W+1)'(FETCH_DEPTH));
    w_state_next = w_issue ? WAIT : w_state_pre;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_req         <= 1'b0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_discard     <= w_discard_next;
      r_req         <= w_issue;
      r_outstanding <= w_issue | (r_outstanding & ~i_imem_rvalid);
      if (w_issue) begin
        r_addr <= w_pc_base;
        r_pc   <= w_pc_base + ADDR_W'(1);
      end else begin
        r_pc   <= w_pc_base;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(FETCH_DEPTH),
    .W    (INSTR_W)
  ) u_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(i_redirect_valid),
    .i_data (i_imem_rdata),
    .o_empty(w_empty),
    .o_count(w_count),
    .o_head (o_instr)
  );

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = !w_empty;
  assign o_halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable
// memory responder and a second instance (RESET_PC=8'hFF) for PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, instr_valid, hazard_stall, redirect_valid, halted;
  logic [7:0]  imem_addr, redirect_pc;
  logic [15:0] imem_rdata, instr;

  logic        wr_req, wr_rvalid, wr_instr_valid, wr_halted, wr_pend;
  logic [7:0]  wr_addr;
  logic [15:0] wr_instr;
  logic [15:0] wr_rdata = 16'h0001;
  logic        wr_stall = 1'b0, wr_redirect = 1'b0;
  logic [7:0]  wr_redirect_pc = 8'h00;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] mem [256];
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [15:0] pend_data;
  logic [7:0]  addr_log [$];
  logic [15:0] pop_log [$];
  logic [7:0]  wrap_log [$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_instr_valid(instr_valid), .o_instr(instr),
    .i_hazard_stall(hazard_stall), .i_redirect_valid(redirect_valid),
    .i_redirect_pc(redirect_pc), .o_halted(halted)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(wr_req), .o_imem_addr(wr_addr),
    .i_imem_rvalid(wr_rvalid), .i_imem_rdata(wr_rdata),
    .o_instr_valid(wr_instr_valid), .o_instr(wr_instr),
    .i_hazard_stall(wr_stall), .i_redirect_valid(wr_redirect),
    .i_redirect_pc(wr_redirect_pc), .o_halted(wr_halted)
  );

  // Memory responder: data captured at request time, rvalid mem_lat cycles later.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
      end
    end
    if (imem_req) begin
      pend_cnt  = mem_lat;
      pend_data = mem[imem_addr];
    end
  end

  always @(negedge clk) begin
    wr_rvalid = wr_pend;
    wr_pend   = wr_req;
  end

  always @(negedge clk) begin
    #1;
    if (imem_req) addr_log.push_back(imem_addr);
    if (instr_valid && !hazard_stall) pop_log.push_back(instr);
    if (wr_req) wrap_log.push_back(wr_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n          = 1'b0;
    hazard_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    repeat (cycles) tick();
    addr_log.delete();
    pop_log.delete();
    wrap_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, instr_valid, 1'b1);
  endtask

  initial begin
    int stall_reqs;
    rst_n = 1'b0;
    hazard_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;

    // Basic fetch, latency 1
    mem_lat = 1;
    do_reset(3);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("wrap_rst_addr", wr_addr, 8'hFF);
    tick();
    check("c1_req", imem_req, 1'b1);
    check("c1_addr", imem_addr, 8'h00);
    tick();
    check("c2_valid", instr_valid, 1'b0);
    tick();
    check("c3_valid", instr_valid, 1'b1);
    check("c3_instr", instr, 16'h1234);
    repeat (6) tick();
    check("basic_addr_n", addr_log.size() >= 3, 1'b1);
    check("basic_addr0", addr_log[0], 8'h00);
    check("basic_addr1", addr_log[1], 8'h01);
    check("basic_addr2", addr_log[2], 8'h02);
    check("basic_pop0", pop_log[0], 16'h1234);
    check("basic_pop1", pop_log[1], 16'h2345);
    check("wrap_addr0", wrap_log[0], 8'hFF);
    check("wrap_addr1", wrap_log[1], 8'h00);

    // Stall hold with head at 16'h1234
    do_reset(2);
    wait_valid("stall_first_valid", 10);
    hazard_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_instr", instr, 16'h1234);
      check("stall_valid", instr_valid, 1'b1);
      tick();
    end
`ifdef FETCH_PREFETCH_EN
    stall_reqs = 2;
`else
    stall_reqs = 1;
`endif
    check("stall_req_count", addr_log.size(), stall_reqs);
    hazard_stall = 1'b0;
    repeat (6) tick();
    check("stall_pop0", pop_log[0], 16'h1234);
    check("stall_pop1", pop_log[1], 16'h2345);

    // Redirect while a latency-3 request is outstanding
    mem[0] = 16'hAAAA; mem[8'h40] = 16'h4040;
    mem_lat = 3;
    do_reset(3);
    tick();
    check("redir_c1_req", imem_req, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_c3_valid", instr_valid, 1'b0);
    tick();
    tick();
    check("redir_c5_req", imem_req, 1'b1);
    check("redir_c5_addr", imem_addr, 8'h40);
    check("redir_c5_valid", instr_valid, 1'b0);
    wait_valid("redir_valid", 12);
    check("redir_instr", instr, 16'h4040);
    tick();
    check("redir_pop0", pop_log[0], 16'h4040);
    check("redir_addr1", addr_log[1], 8'h40);

    // HALT at address 3, then redirect to 0
    mem[0] = 16'h1234; mem[3] = 16'hF000; mem[4] = 16'h5555;
    mem_lat = 1;
    do_reset(3);
    repeat (20) tick();
    check("halt_halted", halted, 1'b1);
    check("halt_req_count", addr_log.size(), 4);
    check("halt_last_addr", addr_log[3], 8'h03);
    check("halt_pop_count", pop_log.size(), 4);
    check("halt_pop_word", pop_log[3], 16'hF000);
    check("halt_drained", instr_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", halted, 1'b0);
    check("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, 8'h00);
    wait_valid("resume_valid", 10);
    check("resume_instr", instr, 16'h1234);

    // One-cycle reset while a latency-2 request is outstanding
    mem[0] = 16'hBAD0;
    mem_lat = 2;
    do_reset(3);
    tick();
    check("mid_c1_req", imem_req, 1'b1);
    tick();
    mem[0] = 16'h600D;
    do_reset(1);
    tick();
    check("mid_new_req", imem_req, 1'b1);
    check("mid_new_addr", imem_addr, 8'h00);
    check("mid_no_push", instr_valid, 1'b0);
    tick();
    check("mid_c2_valid", instr_valid, 1'b0);
    wait_valid("mid_valid", 10);
    check("mid_instr", instr, 16'h600D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
